// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a byte stream MSB-first into DATA_WIDTH-bit words and writes
// them from address 0 while holding the PC. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  abort,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  pc_hold,
    output logic                  done,
    output logic                  error
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD + 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] word_cnt_q;
    logic [BCNT_W-1:0]     byte_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  byte_fire;
    logic                  last_byte;
    logic                  last_word;
    logic                  active;
    logic                  byte_ready_d;
    logic                  wr_en_d;
    logic                  pc_hold_d;
    logic                  done_d;
    logic                  error_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_q;
`endif

`ifdef LOADER_CHECKSUM_EN
    assign active = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHK);
`else
    assign active = (state_q == S_RECV) || (state_q == S_WRITE);
`endif

    // abort wins over a handshake in the same cycle, so the byte is dropped
    assign byte_fire = byte_valid && byte_ready && !abort;
    assign last_byte = byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1);
    assign last_word = word_cnt_q == (len_q - ADDR_WIDTH'(1));
    assign shift_nxt = DATA_WIDTH'({shift_q, byte_in});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            pc_hold    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_ready <= byte_ready_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            pc_hold    <= pc_hold_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (load_len == '0) ? S_DONE : S_RECV;
            end
            S_RECV: begin
                if (abort)                      state_d = S_IDLE;
                else if (byte_fire && last_byte) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort)          state_d = S_IDLE;
`ifdef LOADER_CHECKSUM_EN
                else if (last_word) state_d = S_CHK;
`else
                else if (last_word) state_d = S_DONE;
`endif
                else                state_d = S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (abort)          state_d = S_IDLE;
                else if (byte_fire) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered: decode them from the state being entered
    always_comb begin
`ifdef LOADER_CHECKSUM_EN
        byte_ready_d = (state_d == S_RECV) || (state_d == S_CHK);
`else
        byte_ready_d = (state_d == S_RECV);
`endif
        wr_en_d   = (state_d == S_WRITE);
        pc_hold_d = byte_ready_d || wr_en_d;
        done_d    = (state_d == S_DONE);
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        if (state_q == S_RECV && state_d == S_WRITE) begin
            wr_addr_d = word_cnt_q;
            wr_data_d = shift_nxt;
        end
        error_d = error;
        if (state_q == S_IDLE && start)
            error_d = 1'b0;
        else if (active && abort)
            error_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        else if (state_q == S_CHK && byte_fire && byte_in != xor_q)
            error_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else if (state_q == S_IDLE && start) begin
            len_q      <= load_len;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else if (!abort) begin
            if (state_q == S_RECV && byte_fire) begin
                shift_q    <= shift_nxt;
                byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BCNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                xor_q      <= xor_q ^ byte_in;
`endif
            end
            if (state_q == S_WRITE && !last_word)
                word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
        end
    end

endmodule
